// File: rtl/div_hilo_if.sv
// Pipeline-side bundle for the HI/LO divide sequencer: issue, divider link,
// MFHI/MFLO/MTHI/MTLO access and status.
interface div_hilo_if;
   logic        start;
   logic        is_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic        rd_hilo;
   logic        rd_sel;
   logic [31:0] rd_data;
   logic        mt_en;
   logic        mt_sel;
   logic [31:0] mt_data;
   logic        busy;
   logic        stall;
   logic        done;
   logic        div_zero;

   // master: pipeline and divider side; slave: the sequencer
   modport master (
      output start, is_signed, op_a, op_b, div_q,
      output rd_hilo, rd_sel, mt_en, mt_sel, mt_data,
      input  div_a, div_b, rd_data, busy, stall, done, div_zero
   );

   modport slave (
      input  start, is_signed, op_a, op_b, div_q,
      input  rd_hilo, rd_sel, mt_en, mt_sel, mt_data,
      output div_a, div_b, rd_data, busy, stall, done, div_zero
   );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Multi-cycle sequencer around the external combinational unsigned divider:
// holds operand magnitudes, applies MIPS sign rules and owns the HI/LO registers.
module div_hilo_ctrl #(
   parameter int DIV_CYCLES = 4
) (
   input logic       clk,
   input logic       rst,
   div_hilo_if.slave bus
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, FIX} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   hi, lo;
   logic [31:0]   div_a, div_b;
   logic [31:0]   orig_a;
   logic          s_a, s_b, z;
   logic          done, div_zero;
   logic          busy;
   logic          start_sa, start_sb;
   logic [31:0]   q, r, fix_lo, fix_hi;

   assign start_sa = bus.is_signed & bus.op_a[31];
   assign start_sb = bus.is_signed & bus.op_b[31];

   // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
   always_comb begin
      q      = bus.div_q;
      r      = div_a - q * div_b;
      fix_lo = (s_a ^ s_b) ? -q : q;
      fix_hi = s_a ? -r : r;
      if (z) begin
         fix_lo = '1;
         fix_hi = orig_a;
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         div_a    <= '0;
         div_b    <= '0;
         orig_a   <= '0;
         s_a      <= 1'b0;
         s_b      <= 1'b0;
         z        <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               // An MT alongside Start lands now; the divide overwrites HI/LO later.
               if (bus.mt_en) begin
                  if (bus.mt_sel) hi <= bus.mt_data;
                  else            lo <= bus.mt_data;
               end
               if (bus.start) begin
                  orig_a <= bus.op_a;
                  s_a    <= start_sa;
                  s_b    <= start_sb;
                  z      <= (bus.op_b == '0);
                  div_a  <= start_sa ? -bus.op_a : bus.op_a;
                  div_b  <= start_sb ? -bus.op_b : bus.op_b;
                  cnt    <= CW'(DIV_CYCLES - 1);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - 1'b1;
            end
            FIX: begin
               lo       <= fix_lo;
               hi       <= fix_hi;
               div_zero <= z;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy         = (state != IDLE);
   assign bus.busy     = busy;
   assign bus.stall    = busy & (bus.start | bus.rd_hilo | bus.mt_en);
   assign bus.done     = done;
   assign bus.div_zero = div_zero;
   assign bus.div_a    = div_a;
   assign bus.div_b    = div_b;
   assign bus.rd_data  = bus.rd_sel ? hi : lo;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl: stimulus pushes expected results, a
// negedge monitor pops them on Done and on accepted HI/LO reads.
module tb_div_hilo_ctrl;

   logic clk;
   logic rst;
   div_hilo_if ifc ();

   div_hilo_ctrl #(.DIV_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational divider.
   always_comb begin
      ifc.div_q = 32'hFFFF_FFFF;
      if (ifc.div_b != 32'd0) ifc.div_q = ifc.div_a / ifc.div_b;
   end

   typedef struct {
      logic [31:0] lo;
      logic        dz;
   } div_exp_t;

   div_exp_t    div_q_exp[$];
   logic [31:0] rd_q_exp[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: results on Done, read data on accepted reads.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.done) begin
            if (div_q_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done at %0t", $time);
            end else begin
               div_exp_t e;
               e = div_q_exp.pop_front();
               check("div_zero", {31'd0, ifc.div_zero}, {31'd0, e.dz});
               if (!ifc.rd_sel) check("lo_on_done", ifc.rd_data, e.lo);
            end
         end
         if (ifc.rd_hilo && !ifc.stall) begin
            if (rd_q_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read at %0t", $time);
            end else begin
               check("rd_data", ifc.rd_data, rd_q_exp.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifc.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout at %0t", $time);
      end
      tick();
   endtask

   task automatic rd(input logic sel, input logic [31:0] exp);
      ifc.rd_hilo = 1'b1;
      ifc.rd_sel  = sel;
      rd_q_exp.push_back(exp);
      tick();
      ifc.rd_hilo = 1'b0;
      ifc.rd_sel  = 1'b0;
   endtask

   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic exp_dz);
      div_exp_t e;
      ifc.start     = 1'b1;
      ifc.is_signed = sgn;
      ifc.op_a      = a;
      ifc.op_b      = b;
      e.lo = exp_lo;
      e.dz = exp_dz;
      div_q_exp.push_back(e);
   endtask

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_dz);
      issue(sgn, a, b, exp_lo, exp_dz);
      tick();
      ifc.start = 1'b0;
      wait_done();
      rd(1'b1, exp_hi);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not terminate");
   end

   initial begin
      rst           = 1'b1;
      ifc.start     = 1'b0;
      ifc.is_signed = 1'b0;
      ifc.op_a      = '0;
      ifc.op_b      = '0;
      ifc.rd_hilo   = 1'b0;
      ifc.rd_sel    = 1'b0;
      ifc.mt_en     = 1'b0;
      ifc.mt_sel    = 1'b0;
      ifc.mt_data   = '0;
      tick();
      tick();
      @(negedge clk);
      check("rst_busy",     {31'd0, ifc.busy},     32'd0);
      check("rst_stall",    {31'd0, ifc.stall},    32'd0);
      check("rst_done",     {31'd0, ifc.done},     32'd0);
      check("rst_div_zero", {31'd0, ifc.div_zero}, 32'd0);
      check("rst_div_a",    ifc.div_a,             32'd0);
      check("rst_div_b",    ifc.div_b,             32'd0);
      check("rst_lo",       ifc.rd_data,           32'd0);
      tick();
      rst = 1'b0;
      tick();

      // DIVU 100/7 with cycle-accurate Busy/Done profile.
      issue(1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("busy_c%0d", c), {31'd0, ifc.busy}, {31'd0, (c >= 1 && c <= 5)});
         check($sformatf("done_c%0d", c), {31'd0, ifc.done}, {31'd0, (c == 6)});
         if (c == 1) begin
            check("div_a_held", ifc.div_a, 32'd100);
            check("div_b_held", ifc.div_b, 32'd7);
         end
         tick();
         if (c == 0) ifc.start = 1'b0;
      end
      rd(1'b1, 32'd2);

      do_div(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      do_div(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
      do_div(1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,         1'b0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
      do_div(1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,         1'b1);
      do_div(1'b0, 32'd9,         32'd3,          32'd3,         32'd0,         1'b0);

      // Read and second divide held from cycle 2: stalled until the Done cycle.
      issue(1'b0, 32'd20, 32'd3, 32'd6, 1'b0);
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         if (c >= 2) check($sformatf("stall_c%0d", c), {31'd0, ifc.stall}, {31'd0, (c <= 5)});
         tick();
         if (c == 0) ifc.start = 1'b0;
         if (c == 1) begin
            ifc.rd_hilo = 1'b1;
            ifc.rd_sel  = 1'b0;
            rd_q_exp.push_back(32'd6);
            issue(1'b0, 32'd9, 32'd3, 32'd3, 1'b0);
         end
      end
      ifc.start   = 1'b0;
      ifc.rd_hilo = 1'b0;
      wait_done();
      rd(1'b1, 32'd0);

      // MTHI in IDLE, then MT attempted while busy.
      ifc.mt_en   = 1'b1;
      ifc.mt_sel  = 1'b1;
      ifc.mt_data = 32'h1234_5678;
      tick();
      ifc.mt_en = 1'b0;
      rd(1'b1, 32'h1234_5678);
      issue(1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
      tick();
      ifc.start = 1'b0;
      tick();
      ifc.mt_en   = 1'b1;
      ifc.mt_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("mt_busy_stall", {31'd0, ifc.stall}, 32'd1);
      tick();
      ifc.mt_en  = 1'b0;
      ifc.mt_sel = 1'b0;
      wait_done();
      rd(1'b1, 32'd2);

      // MT together with Start: divide result wins.
      ifc.mt_en   = 1'b1;
      ifc.mt_sel  = 1'b0;
      ifc.mt_data = 32'h0000_AAAA;
      do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      ifc.mt_en = 1'b0;

      // Reset in cycle 3 aborts the divide.
      issue(1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
      void'(div_q_exp.pop_back());
      tick();
      ifc.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, ifc.busy}, 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("abort_no_done", {31'd0, ifc.done}, 32'd0);
      end
      tick();
      rd(1'b0, 32'd0);
      rd(1'b1, 32'd0);
      do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

      tick();
      tick();
      check("div_queue_empty", div_q_exp.size(), 32'd0);
      check("rd_queue_empty",  rd_q_exp.size(),  32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
